// File: rtl/mux_burst_arbiter_if.sv
// Bus bundle between the requester side and the burst arbiter.
// The master side drives requests, words and back-pressure; the slave side returns the muxed beat.
interface mux_burst_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 7
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic                      out_ready;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic [ID_W-1:0]           active_id;
  logic                      busy;

  modport master (
    output req, data_in, out_ready,
    input  gnt, out_data, out_valid, active_id, busy
  );

  modport slave (
    input  req, data_in, out_ready,
    output gnt, out_data, out_valid, active_id, busy
  );
endinterface

// File: rtl/mux_burst_arbiter.sv
// Round-robin burst arbiter driving a shared registered output mux.
// One owner at a time forwards up to MAX_BURST beats, then priority rotates past it.
module mux_burst_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 7,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux_burst_arbiter_if.slave bus
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_TURN
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic [ID_W-1:0]     r_active_id;
  logic                r_busy;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]    r_burst_cnt;

  state_t              w_state_nxt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [DATA_W-1:0]   w_out_data_nxt;
  logic                w_out_valid_nxt;
  logic [ID_W-1:0]     w_active_id_nxt;
  logic [ID_W-1:0]     w_rr_ptr_nxt;
  logic [CNT_W-1:0]    w_burst_cnt_nxt;

  logic [DATA_W-1:0]   w_words [NUM_REQ];
  logic [ID_W-1:0]     w_pick;
  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [ID_W-1:0]     w_ptr_inc;
  logic                w_owner_req;
  logic                w_beat;
  logic                w_last_beat;

  // First set request bit at or after ptr, wrapping; lowest offset wins.
  function automatic logic [ID_W-1:0] f_pick(input logic [NUM_REQ-1:0] req_vec,
                                             input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    int unsigned     idx;
    pick = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + (NUM_REQ - 1 - k);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_vec[ID_W'(idx)]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign w_words[gi] = bus.data_in[gi*DATA_W +: DATA_W];
  end

  assign w_pick        = f_pick(bus.req, r_rr_ptr);
  assign w_pick_onehot = NUM_REQ'(1) << w_pick;
  assign w_ptr_inc     = (r_active_id == ID_W'(NUM_REQ - 1)) ? '0 : r_active_id + ID_W'(1);
  assign w_owner_req   = bus.req[r_active_id];
  assign w_beat        = w_owner_req & bus.out_ready;
  assign w_last_beat   = (r_burst_cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_active_id <= '0;
      r_busy      <= 1'b0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_active_id <= w_active_id_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = 1'b0;
    w_active_id_nxt = r_active_id;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
          w_state_nxt     = ST_GRANT;
          w_gnt_nxt       = w_pick_onehot;
          w_active_id_nxt = w_pick;
          w_burst_cnt_nxt = '0;
        end
      end

      ST_GRANT: begin
        // Owner dropping its request ends the burst without a beat.
        if (!w_owner_req) begin
          w_state_nxt  = ST_TURN;
          w_gnt_nxt    = '0;
          w_rr_ptr_nxt = w_ptr_inc;
        end else if (w_beat) begin
          w_out_data_nxt  = w_words[r_active_id];
          w_out_valid_nxt = 1'b1;
          w_burst_cnt_nxt = r_burst_cnt + CNT_W'(1);
          if (w_last_beat) begin
            w_state_nxt  = ST_TURN;
            w_gnt_nxt    = '0;
            w_rr_ptr_nxt = w_ptr_inc;
          end
        end
      end

      ST_TURN: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  assign bus.gnt       = r_gnt;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.active_id = r_active_id;
  assign bus.busy      = r_busy;

  // Grant encoding invariants.
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
  a_gnt_in_grant: assert property (@(posedge clk) disable iff (rst)
                                   (r_gnt != '0) |-> (r_state == ST_GRANT));

endmodule

// File: tb/tb_mux_burst_arbiter.sv
// Directed bench for mux_burst_arbiter: a vector table for the basic burst plus
// hand-written sequences for rotation, back-pressure, early release, reset and MAX_BURST=1.
module tb_mux_burst_arbiter;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_cmp;
  int n_err;

  mux_burst_arbiter_if #(.NUM_REQ(4), .DATA_W(7)) bus_a ();
  mux_burst_arbiter_if #(.NUM_REQ(4), .DATA_W(7)) bus_b ();

  mux_burst_arbiter #(.NUM_REQ(4), .DATA_W(7), .MAX_BURST(8)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  mux_burst_arbiter #(.NUM_REQ(4), .DATA_W(7), .MAX_BURST(1)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [6:0] d0;
    logic       rdy;
    logic [3:0] e_gnt;
    logic       e_valid;
    logic [6:0] e_data;
    logic [1:0] e_id;
    logic       e_busy;
  } vec_t;

  vec_t tv [13];

  logic [3:0] e_gnt;
  logic       e_valid;
  logic [6:0] e_data;
  logic [1:0] e_id;
  logic       e_busy;
  int         k;
  int         o;
  int         pulses;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_a(input string tag, input int cyc, input logic [3:0] eg, input logic ev,
                         input logic [6:0] ed, input logic [1:0] eid, input logic eb, input bit do_data);
    chk({tag, ".gnt"},   cyc, 32'(bus_a.gnt),       32'(eg));
    chk({tag, ".valid"}, cyc, 32'(bus_a.out_valid), 32'(ev));
    chk({tag, ".id"},    cyc, 32'(bus_a.active_id), 32'(eid));
    chk({tag, ".busy"},  cyc, 32'(bus_a.busy),      32'(eb));
    if (do_data) chk({tag, ".data"}, cyc, 32'(bus_a.out_data), 32'(ed));
  endtask

  task automatic check_b(input string tag, input int cyc, input logic [3:0] eg, input logic ev,
                         input logic [6:0] ed, input logic [1:0] eid, input logic eb, input bit do_data);
    chk({tag, ".gnt"},   cyc, 32'(bus_b.gnt),       32'(eg));
    chk({tag, ".valid"}, cyc, 32'(bus_b.out_valid), 32'(ev));
    chk({tag, ".id"},    cyc, 32'(bus_b.active_id), 32'(eid));
    chk({tag, ".busy"},  cyc, 32'(bus_b.busy),      32'(eb));
    if (do_data) chk({tag, ".data"}, cyc, 32'(bus_b.out_data), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words_a(input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
    bus_a.data_in = {d3, d2, d1, d0};
  endtask

  // Leaves the bench at cycle 0: one tick after an edge, reset just released.
  task automatic reset_a();
    rst_a           = 1'b1;
    bus_a.req       = '0;
    bus_a.out_ready = 1'b0;
    tick();
    tick();
    rst_a = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.req = '0; bus_a.data_in = '0; bus_a.out_ready = 1'b0;
    bus_b.req = '0; bus_b.data_in = '0; bus_b.out_ready = 1'b0;

    // Row c: inputs driven during cycle c, outputs expected at the start of cycle c.
    tv[0]  = '{4'b0001, 7'h00, 1'b1, 4'b0000, 1'b0, 7'h00, 2'd0, 1'b0};
    tv[1]  = '{4'b0001, 7'h01, 1'b1, 4'b0001, 1'b0, 7'h00, 2'd0, 1'b1};
    tv[2]  = '{4'b0001, 7'h02, 1'b1, 4'b0001, 1'b1, 7'h01, 2'd0, 1'b1};
    tv[3]  = '{4'b0001, 7'h03, 1'b1, 4'b0001, 1'b1, 7'h02, 2'd0, 1'b1};
    tv[4]  = '{4'b0001, 7'h04, 1'b1, 4'b0001, 1'b1, 7'h03, 2'd0, 1'b1};
    tv[5]  = '{4'b0001, 7'h05, 1'b1, 4'b0001, 1'b1, 7'h04, 2'd0, 1'b1};
    tv[6]  = '{4'b0001, 7'h06, 1'b1, 4'b0001, 1'b1, 7'h05, 2'd0, 1'b1};
    tv[7]  = '{4'b0001, 7'h07, 1'b1, 4'b0001, 1'b1, 7'h06, 2'd0, 1'b1};
    tv[8]  = '{4'b0001, 7'h08, 1'b1, 4'b0001, 1'b1, 7'h07, 2'd0, 1'b1};
    tv[9]  = '{4'b0001, 7'h09, 1'b1, 4'b0000, 1'b1, 7'h08, 2'd0, 1'b1};
    tv[10] = '{4'b0001, 7'h0A, 1'b1, 4'b0000, 1'b0, 7'h08, 2'd0, 1'b0};
    tv[11] = '{4'b0001, 7'h0B, 1'b1, 4'b0001, 1'b0, 7'h08, 2'd0, 1'b1};
    tv[12] = '{4'b0001, 7'h0C, 1'b1, 4'b0001, 1'b1, 7'h0B, 2'd0, 1'b1};

    // Single requester, full burst, regrant after TURN+IDLE.
    reset_a();
    for (int c = 0; c < 13; c++) begin
      check_a("t1", c, tv[c].e_gnt, tv[c].e_valid, tv[c].e_data, tv[c].e_id, tv[c].e_busy, 1'b1);
      bus_a.req       = tv[c].req;
      bus_a.out_ready = tv[c].rdy;
      set_words_a(tv[c].d0, 7'h55, 7'h66, 7'h77);
      tick();
    end

    // All four requesting: order 0,1,2,3,0, 8 beats each, 10-cycle period.
    reset_a();
    set_words_a(7'h10, 7'h11, 7'h12, 7'h13);
    bus_a.req       = 4'b1111;
    bus_a.out_ready = 1'b1;
    for (int c = 0; c <= 50; c++) begin
      if (c == 0) begin
        e_gnt = '0; e_valid = 1'b0; e_busy = 1'b0; e_id = '0; e_data = '0;
      end else begin
        k       = (c - 1) / 10;
        o       = (c - 1) % 10;
        e_gnt   = (o <= 7) ? 4'(1 << (k % 4)) : 4'b0000;
        e_valid = (o >= 1 && o <= 8);
        e_busy  = (o <= 8);
        e_id    = 2'(k % 4);
        e_data  = 7'(16 + k % 4);
      end
      check_a("t2", c, e_gnt, e_valid, e_data, e_id, e_busy, e_valid);
      chk("t2.onehot0", c, 32'($onehot0(bus_a.gnt)), 32'd1);
      tick();
    end

    // Back-pressure: out_ready toggles, burst stretches to 16 cycles.
    reset_a();
    for (int c = 0; c <= 18; c++) begin
      e_gnt   = ((c >= 1 && c <= 15) || c == 18) ? 4'b0010 : 4'b0000;
      e_valid = (c % 2 == 0 && c >= 2 && c <= 16);
      e_data  = (c < 2) ? 7'h00 : ((c % 2 == 0) ? 7'(c - 1) : 7'(c - 2));
      e_busy  = ((c >= 1 && c <= 16) || c == 18);
      e_id    = (c >= 1) ? 2'd1 : 2'd0;
      check_a("t3", c, e_gnt, e_valid, e_data, e_id, e_busy, (c <= 17));
      bus_a.req       = 4'b0010;
      bus_a.out_ready = (c % 2 == 1);
      set_words_a(7'h55, 7'(c), 7'h66, 7'h77);
      tick();
    end

    // Owner 2 releases after 3 beats; scan from pointer 3 wraps to 0.
    reset_a();
    pulses = 0;
    set_words_a(7'h11, 7'h55, 7'h2A, 7'h4D);
    bus_a.out_ready = 1'b1;
    bus_a.req       = 4'b0100;
    tick();
    check_a("t4", 1, 4'b0100, 1'b0, 7'h00, 2'd2, 1'b1, 1'b1);
    bus_a.req = 4'b0101;
    tick();
    pulses += int'(bus_a.out_valid);
    check_a("t4", 2, 4'b0100, 1'b1, 7'h2A, 2'd2, 1'b1, 1'b1);
    tick();
    pulses += int'(bus_a.out_valid);
    check_a("t4", 3, 4'b0100, 1'b1, 7'h2A, 2'd2, 1'b1, 1'b1);
    tick();
    pulses += int'(bus_a.out_valid);
    check_a("t4", 4, 4'b0100, 1'b1, 7'h2A, 2'd2, 1'b1, 1'b1);
    bus_a.req = 4'b0001;
    tick();
    pulses += int'(bus_a.out_valid);
    check_a("t4", 5, 4'b0000, 1'b0, 7'h2A, 2'd2, 1'b1, 1'b1);
    tick();
    pulses += int'(bus_a.out_valid);
    check_a("t4", 6, 4'b0000, 1'b0, 7'h2A, 2'd2, 1'b0, 1'b1);
    tick();
    pulses += int'(bus_a.out_valid);
    check_a("t4", 7, 4'b0001, 1'b0, 7'h2A, 2'd0, 1'b1, 1'b1);
    chk("t4.pulses", 7, 32'(pulses), 32'd3);

    // Continue owner 0's burst, then reset asynchronously during beat 4.
    tick();
    check_a("t5", 8, 4'b0001, 1'b1, 7'h11, 2'd0, 1'b1, 1'b1);
    tick();
    tick();
    check_a("t5", 10, 4'b0001, 1'b1, 7'h11, 2'd0, 1'b1, 1'b1);
    #2;
    rst_a = 1'b1;
    #1;
    check_a("t5.async", 10, 4'b0000, 1'b0, 7'h00, 2'd0, 1'b0, 1'b1);
    bus_a.req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    tick();
    check_a("t5.post", 1, 4'b1000, 1'b0, 7'h00, 2'd3, 1'b1, 1'b1);
    tick();
    check_a("t5.post", 2, 4'b1000, 1'b1, 7'h4D, 2'd3, 1'b1, 1'b1);

    // MAX_BURST=1: grants alternate 0,2,0,2 with one beat each.
    rst_a = 1'b1;
    bus_b.req       = '0;
    bus_b.out_ready = 1'b1;
    bus_b.data_in   = {7'h77, 7'h25, 7'h66, 7'h05};
    tick();
    tick();
    rst_b = 1'b0;
    bus_b.req = 4'b0101;
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) begin
        e_gnt = '0; e_valid = 1'b0; e_busy = 1'b0; e_id = '0; e_data = '0;
      end else begin
        k       = (c - 1) / 3;
        o       = (c - 1) % 3;
        e_gnt   = (o == 0) ? ((k % 2 == 0) ? 4'b0001 : 4'b0100) : 4'b0000;
        e_valid = (o == 1);
        e_busy  = (o <= 1);
        e_id    = (k % 2 == 0) ? 2'd0 : 2'd2;
        e_data  = (k % 2 == 0) ? 7'h05 : 7'h25;
      end
      check_b("t6", c, e_gnt, e_valid, e_data, e_id, e_busy, (c == 0) || e_valid);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
